// File: rtl/cachepkg.sv
// Shared cache types: operation encoding, arbiter FSM states and a small index helper.
package cachepkg;

  typedef enum logic [1:0] {
    InstRead  = 2'd0,
    InstWrite = 2'd1,
    InstEvict = 2'd2,
    InstFlush = 2'd3
  } inst_t;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StRespond = 2'd2,
    StRelease = 2'd3
  } arb_state_t;

  // Increment an index modulo n without a divider.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick
  import cachepkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned IdxW      = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IdxW-1:0]      ptr_i,
  output logic [IdxW-1:0]      grant_o,
  output logic                 any_req_o
);

  always_comb begin
    int unsigned idx;
    grant_o   = ptr_i;
    any_req_o = 1'b0;
    idx       = 32'(ptr_i);
    for (int unsigned off = 0; off < NUM_PORTS; off++) begin
      if (!any_req_o && req_i[IdxW'(idx)]) begin
        grant_o   = IdxW'(idx);
        any_req_o = 1'b1;
      end
      idx = wrap_inc(idx, NUM_PORTS);
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin front end multiplexing NUM_PORTS masters onto one cache slave port.
// Optional watchdog enabled by defining CACHE_ARB_TIMEOUT_EN.
module cache_port_arbiter
  import cachepkg::*;
#(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned DATAWIDTH      = 8,
  parameter int unsigned ADDRESSWIDTH   = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                              clock,
  input  logic                              reset,
  input  inst_t [NUM_PORTS-1:0]             up_operation,
  input  logic  [NUM_PORTS*ADDRESSWIDTH-1:0] up_addr,
  input  logic  [NUM_PORTS*DATAWIDTH-1:0]   up_wdata,
  input  logic  [NUM_PORTS-1:0]             up_request,
  output logic  [NUM_PORTS-1:0]             up_valid,
  output logic  [NUM_PORTS-1:0]             up_evict,
  output logic  [DATAWIDTH-1:0]             up_rdata,
  output inst_t                             ds_operation,
  output logic  [ADDRESSWIDTH-1:0]          ds_addr,
  output logic  [DATAWIDTH-1:0]             ds_wdata,
  output logic                              ds_request,
  input  logic                              ds_valid,
  input  logic                              ds_evict,
  input  logic  [DATAWIDTH-1:0]             ds_rdata,
  output logic                              timeout_err
);

  localparam int unsigned IdxW = $clog2(NUM_PORTS);

  arb_state_t               state_q, state_d;
  logic [IdxW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]          grant_q, grant_d;
  inst_t                    op_q, op_d;
  logic [ADDRESSWIDTH-1:0]  addr_q, addr_d;
  logic [DATAWIDTH-1:0]     wdata_q, wdata_d;
  logic [DATAWIDTH-1:0]     rdata_q, rdata_d;
  logic [NUM_PORTS-1:0]     up_valid_q, up_valid_d;
  logic [NUM_PORTS-1:0]     up_evict_q, up_evict_d;
  logic                     ds_request_q, ds_request_d;

  logic [IdxW-1:0]          pick_idx;
  logic                     any_req;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IdxW      (IdxW)
  ) u_rr_pick (
    .req_i     (up_request),
    .ptr_i     (rr_ptr_q),
    .grant_o   (pick_idx),
    .any_req_o (any_req)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    up_valid_d   = up_valid_q;
    up_evict_d   = up_evict_q;
    ds_request_d = ds_request_q;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          grant_d      = pick_idx;
          op_d         = up_operation[pick_idx];
          addr_d       = up_addr[32'(pick_idx) * ADDRESSWIDTH +: ADDRESSWIDTH];
          wdata_d      = up_wdata[32'(pick_idx) * DATAWIDTH +: DATAWIDTH];
          ds_request_d = 1'b1;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        if (ds_valid) begin
          rdata_d             = ds_rdata;
          ds_request_d        = 1'b0;
          up_valid_d          = '0;
          up_valid_d[grant_q] = 1'b1;
          up_evict_d          = '0;
          up_evict_d[grant_q] = ds_evict;
          state_d             = StRespond;
        end
      end
      StRespond: begin
        // A master that already dropped its request still gets a full completion.
        if (!up_request[grant_q] && !ds_valid) begin
          up_valid_d = '0;
          up_evict_d = '0;
          rr_ptr_d   = IdxW'(wrap_inc(32'(grant_q), NUM_PORTS));
          state_d    = StRelease;
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      op_q         <= InstRead;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      up_valid_q   <= '0;
      up_evict_q   <= '0;
      ds_request_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      up_valid_q   <= up_valid_d;
      up_evict_q   <= up_evict_d;
      ds_request_q <= ds_request_d;
    end
  end

  assign up_valid     = up_valid_q;
  assign up_evict     = up_evict_q;
  assign up_rdata     = rdata_q;
  assign ds_operation = op_q;
  assign ds_addr      = addr_q;
  assign ds_wdata     = wdata_q;
  assign ds_request   = ds_request_q;

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] to_cnt_q, to_cnt_d;
  logic            to_err_q, to_err_d;

  // Counter saturates at the limit; the error flag is sticky until reset.
  always_comb begin
    to_cnt_d = '0;
    to_err_d = to_err_q;
    if (state_q == StIssue) begin
      to_cnt_d = (to_cnt_q == CntW'(TIMEOUT_CYCLES)) ? to_cnt_q : to_cnt_q + CntW'(1);
      if (to_cnt_d == CntW'(TIMEOUT_CYCLES)) begin
        to_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign timeout_err = to_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_err        = 1'b0;
`endif

endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

Multi-channel front end for a single cache slave port. It accepts up to NUM_PORTS independent masters, each speaking the cache 4-phase request/valid handshake with an evict indication. Masters are arbitrated round-robin and one transaction at a time is forwarded to the downstream cache. Data buses are split into unidirectional write and read paths, so there are no inout buses.

## Interface
- NUM_PORTS, 4: number of upstream master channels, 2..16.
- DATAWIDTH, 8: data bits per transaction.
- ADDRESSWIDTH, 32: address bits.
- TIMEOUT_CYCLES, 1024: watchdog limit; used only with the timeout feature.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- up_operation  in  NUM_PORTS x inst_t  per-port operation.
- up_addr  in  NUM_PORTS*ADDRESSWIDTH  per-port address, flattened; port i occupies slice i.
- up_wdata  in  NUM_PORTS*DATAWIDTH  per-port write data.
- up_request  in  NUM_PORTS  per-port request.
- up_valid  out  NUM_PORTS  per-port completion; one-hot or zero.
- up_evict  out  NUM_PORTS  per-port evict flag; qualified by up_valid.
- up_rdata  out  DATAWIDTH  read data; shared by all ports and qualified by up_valid.
- ds_operation  out  inst_t  downstream operation.
- ds_addr  out  ADDRESSWIDTH  downstream address.
- ds_wdata  out  DATAWIDTH  downstream write data.
- ds_request  out  1  downstream request.
- ds_valid  in  1  downstream completion.
- ds_evict  in  1  downstream evict.
- ds_rdata  in  DATAWIDTH  downstream read data.
- timeout_err  out  1  sticky watchdog error flag.

## Operation
- FSM states: IDLE, ISSUE, RESPOND, RELEASE.
- IDLE: if any up_request bit is set, select the winner by round-robin starting at rr_ptr. Register the winner's index, operation, addr and wdata; go to ISSUE.
- ISSUE: ds_request=1 with the captured fields held stable. On ds_valid=1: latch ds_rdata and ds_evict, drive ds_request=0, up_valid[grant]=1, and go to RESPOND.
- RESPOND: hold up_valid[grant], up_rdata and up_evict[grant]. When up_request[grant]=0 and ds_valid=0, drive up_valid=0, set rr_ptr=(grant+1) mod NUM_PORTS, and go to RELEASE.
- RELEASE: one idle cycle, then go to IDLE. This guarantees each master sees valid low before any re-grant.
- Non-granted requests stay pending with no response. A port is never granted twice in a row while another port is requesting.
- If the granted master drops up_request before completion (protocol violation), the transaction still completes. RESPOND then exits as soon as ds_valid is low.
- Reset values: all outputs 0, ds_operation=0, state IDLE, rr_ptr=0, timeout_err=0. Reset asserted mid-transaction drops ds_request and up_valid immediately and discards the transaction.

## Timing
- Upstream request sampled high in IDLE at cycle 0: ds_request rises at cycle 1.
- ds_valid sampled high at cycle k: up_valid rises and ds_request falls at cycle k+1.
- Minimum request-to-valid latency: 2 cycles plus downstream latency.
- Minimum gap between consecutive grants: 2 cycles after up_valid falls.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- CACHE_ARB_TIMEOUT_EN defined: a counter runs while in ISSUE and clears on leaving ISSUE. When it reaches TIMEOUT_CYCLES, timeout_err is set and stays set until reset; the transaction keeps waiting.
- CACHE_ARB_TIMEOUT_EN undefined: no counter is built and timeout_err is tied to 0.

## Structure
- cachepkg: inst_t already lives here. Add arb_state_t, the enum of the four FSM states.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: grant index, any_req.

## Test plan
- Single port 2 requests write, addr 0x1000, wdata 0xA5; ds_valid after 3 cycles -> ds_addr=0x1000, ds_wdata=0xA5; up_valid[2] rises 1 cycle after ds_valid.
- Ports 0, 1, 3 request simultaneously from reset -> grant order 0, 1, 3; rr_ptr=0 after port 3 completes.
- Port 0 re-requests immediately while port 1 is pending -> port 1 is granted before port 0.
- ds_evict=1, ds_rdata=0x3C with ds_valid -> up_evict[grant]=1, up_rdata=0x3C while up_valid is high.
- reset pulled low during ISSUE -> ds_request=0 and up_valid=0 immediately; first grant after reset goes to the lowest requesting port.
- CACHE_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, ds_valid held low -> timeout_err=1 after 16 ISSUE cycles; it remains 1 after the late ds_valid completes the transaction.
